// File: rtl/mem_read_streamer.sv
// -----------------------------------------------------------------------------
// mem_read_streamer
//
// Reads a burst of LEN consecutive words from a synchronous-read memory,
// starting at BASE_ADDR (wrapping modulo 2^ADDR_W), and streams them out over
// a valid/ready interface. A 2-entry output FIFO decouples memory latency
// from downstream backpressure; reads are throttled so that entries held,
// plus the read in flight, minus the word leaving this cycle, never exceed
// the FIFO depth.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   START      burst request, sampled only while idle
//   BASE_ADDR  first word address, captured with START
//   LEN        word count (clamped to 2^ADDR_W), captured with START
//   BUSY       high while a burst is running
//   DONE       one-cycle pulse when a burst finishes
//   MEM_EN     memory read enable, one read per high cycle
//   MEM_WRITE  memory write strobe, tied low
//   MEM_ADDR   memory read address (0 while MEM_EN is low)
//   MEM_DATA   memory read data, valid the cycle after MEM_EN
//   OUT_VALID  downstream word valid
//   OUT_DATA   downstream word (0 while OUT_VALID is low)
//   OUT_READY  downstream accept
// -----------------------------------------------------------------------------
module mem_read_streamer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              MEM_EN,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              OUT_VALID,
  output logic [DATA_W-1:0] OUT_DATA,
  input  logic              OUT_READY
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued_q;      // reads issued so far
  logic [ADDR_W:0]   delivered_q;   // words handed downstream so far
  logic              inflight_q;    // a read was issued last cycle
  logic [1:0]        occ_q;         // FIFO entries held
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [DATA_W-1:0] fifo_q [2];

  logic [ADDR_W:0]   len_eff;
  logic              pop;
  logic              words_left;
  logic              last_pop;
  logic              mem_en;

  // Requests longer than the address space read every word exactly once.
  assign len_eff    = (LEN > MAX_LEN) ? MAX_LEN : LEN;

  assign OUT_VALID  = (occ_q != 2'd0);
  assign OUT_DATA   = OUT_VALID ? fifo_q[rd_ptr_q] : '0;
  assign pop        = OUT_VALID && OUT_READY;
  assign words_left = (issued_q != len_q);
  assign last_pop   = pop && ((delivered_q + ONE) == len_q);

  // Issue only if the returning word is guaranteed a free FIFO slot. Counting
  // this cycle's pop lets a full FIFO keep streaming at one word per cycle,
  // at the cost of a combinational path from OUT_READY to MEM_EN.
  assign mem_en = (state_q == RUN) && words_left &&
                  (({1'b0, occ_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop}));

  assign MEM_EN    = mem_en;
  assign MEM_WRITE = 1'b0;
  assign MEM_ADDR  = mem_en ? (base_q + issued_q[ADDR_W-1:0]) : '0;
  assign BUSY      = (state_q == RUN);
  assign DONE      = (state_q == FINISH);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (START) state_nxt = (len_eff == '0) ? FINISH : RUN;
      RUN:     if (last_pop) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == IDLE && START) begin
        base_q      <= BASE_ADDR;
        len_q       <= len_eff;
        issued_q    <= '0;
        delivered_q <= '0;
      end
      if (mem_en) issued_q <= issued_q + ONE;
      if (pop) begin
        delivered_q <= delivered_q + ONE;
        rd_ptr_q    <= ~rd_ptr_q;
      end
      // Clearing inflight on reset is what discards a read return in flight.
      inflight_q <= mem_en;
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy is, and it alone
  // decides whether an entry is visible, so stale contents never escape.
  always_ff @(posedge CLK) begin
    if (inflight_q) fifo_q[wr_ptr_q] <= MEM_DATA;
  end

endmodule

// File: tb/tb_mem_read_streamer.sv
module tb_mem_read_streamer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  BASE_ADDR;
  logic [8:0]  LEN;
  logic        BUSY, DONE, MEM_EN, MEM_WRITE, OUT_VALID, OUT_READY;
  logic [7:0]  MEM_ADDR;
  logic [15:0] MEM_DATA;
  logic [15:0] OUT_DATA;

  mem_read_streamer #(.DATA_W(16), .ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .MEM_EN(MEM_EN), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .OUT_VALID(OUT_VALID),
    .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  // Memory model: synchronous read, junk on the bus when not reading.
  logic [15:0] mem [256];
  always @(posedge CLK) MEM_DATA <= MEM_EN ? mem[MEM_ADDR] : 16'($urandom);

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_addr [$];
  logic [15:0] exp_data [$];
  bit          mon_on = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  int          last_xfer_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flush();
    exp_addr.delete();
    exp_data.delete();
  endtask

  // Reference: a burst reads words base, base+1, ... (mod 256), min(len,256) of them.
  task automatic push_burst(input logic [7:0] base, input logic [8:0] len, output int n);
    n = (len > 9'd256) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = base + 8'(i);
      exp_addr.push_back(a);
      exp_data.push_back(mem[a]);
    end
  endtask

  // Monitor: pops expected reads/words whenever the DUT presents them.
  always @(negedge CLK) begin
    if (mon_on) begin
      check("mem_write low", 32'(MEM_WRITE), 32'd0);
      if (MEM_EN) begin
        if (exp_addr.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious read: addr %0h, none expected", MEM_ADDR);
        end else check("read addr", 32'(MEM_ADDR), 32'(exp_addr.pop_front()));
      end else check("addr zero when idle", 32'(MEM_ADDR), 32'd0);
      if (OUT_VALID && OUT_READY) begin
        last_xfer_cyc = cyc;
        if (exp_data.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious word: data %0h, none expected", OUT_DATA);
        end else check("out data", 32'(OUT_DATA), 32'(exp_data.pop_front()));
      end
      if (!OUT_VALID) check("data zero when invalid", 32'(OUT_DATA), 32'd0);
      if (prev_stall) begin
        check("stall holds valid", 32'(OUT_VALID), 32'd1);
        check("stall holds data", 32'(OUT_DATA), 32'(prev_data));
      end
      prev_stall = OUT_VALID && !OUT_READY && !RST;
      prev_data  = OUT_DATA;
    end
  end

  // Fixed-timing burst with OUT_READY high: reads in cycles 1..n, words in
  // 3..n+2, DONE in n+3 (cycle 1 for an empty burst). Optionally pulses a
  // conflicting START in cycle 2. Entered and left at the start of an idle cycle.
  task automatic timed_burst(input logic [7:0] base, input logic [8:0] len, input bit junk);
    int n;
    int done_c;
    push_burst(base, len, n);
    done_c = (n == 0) ? 1 : n + 3;
    START = 1'b1; BASE_ADDR = base; LEN = len; OUT_READY = 1'b1;
    for (int c = 0; c <= done_c + 1; c++) begin
      @(negedge CLK);
      check($sformatf("busy b%0h c%0d", base, c), 32'(BUSY), 32'(n > 0 && c >= 1 && c <= n + 2));
      check($sformatf("done b%0h c%0d", base, c), 32'(DONE), 32'(c == done_c));
      check($sformatf("mem_en b%0h c%0d", base, c), 32'(MEM_EN), 32'(n > 0 && c >= 1 && c <= n));
      check($sformatf("valid b%0h c%0d", base, c), 32'(OUT_VALID), 32'(n > 0 && c >= 3 && c <= n + 2));
      @(posedge CLK); #1;
      START = junk && (c + 1 == 2);
      if (START) begin BASE_ADDR = 8'h80; LEN = 9'd3; end
    end
    check("reads left over", 32'(exp_addr.size()), 32'd0);
    check("words left over", 32'(exp_data.size()), 32'd0);
  endtask

  // Waits for DONE; in random mode it also toggles OUT_READY and fires
  // START pulses while busy. Returns at the start of the idle cycle after DONE.
  task automatic wait_done(input int budget, input bit rnd, output int done_cyc);
    bit was_busy;
    done_cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (DONE) done_cyc = cyc;
      was_busy = BUSY;
      @(posedge CLK); #1;
      START = 1'b0;
      if (rnd) begin
        OUT_READY = ($urandom % 4) != 0;
        if (was_busy && ($urandom % 8) == 0) begin
          START = 1'b1; BASE_ADDR = 8'($urandom); LEN = 9'($urandom);
        end
      end
      if (done_cyc >= 0) break;
    end
    if (done_cyc < 0) begin
      total++; bad++;
      $display("FAIL done timeout: no DONE within %0d cycles", budget);
      RST = 1'b1; @(posedge CLK); #1; RST = 1'b0;
      flush();
    end
  endtask

  initial begin
    int n, t0, done_cyc;
    RST = 1'b1; START = 1'b0; BASE_ADDR = '0; LEN = '0; OUT_READY = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h1000 + 16'(a);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset busy", 32'(BUSY), 32'd0);
    check("reset done", 32'(DONE), 32'd0);
    check("reset mem_en", 32'(MEM_EN), 32'd0);
    check("reset mem_addr", 32'(MEM_ADDR), 32'd0);
    check("reset valid", 32'(OUT_VALID), 32'd0);
    check("reset out_data", 32'(OUT_DATA), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; mon_on = 1'b1;

    timed_burst(8'h10, 9'd4, 1'b0);     // basic
    timed_burst(8'hFE, 9'd4, 1'b0);     // address wrap
    timed_burst(8'h33, 9'd0, 1'b0);     // zero length
    timed_burst(8'h10, 9'd4, 1'b1);     // START while busy is ignored
    timed_burst(8'h05, 9'd300, 1'b0);   // clamp to 256 words

    // Backpressure: OUT_READY low in cycles 3..10.
    push_burst(8'h10, 9'd8, n);
    START = 1'b1; BASE_ADDR = 8'h10; LEN = 9'd8; OUT_READY = 1'b1;
    t0 = cyc;
    for (int c = 0; c <= 10; c++) begin
      @(negedge CLK);
      check($sformatf("bp mem_en c%0d", c), 32'(MEM_EN), 32'(c == 1 || c == 2));
      if (c >= 3) begin
        check($sformatf("bp valid c%0d", c), 32'(OUT_VALID), 32'd1);
        check($sformatf("bp data c%0d", c), 32'(OUT_DATA), 32'h1010);
      end
      @(posedge CLK); #1;
      START = 1'b0;
      OUT_READY = !((c + 1) >= 3 && (c + 1) <= 10);
    end
    wait_done(40, 1'b0, done_cyc);
    check("bp done cycle", 32'(done_cyc - t0), 32'd19);
    check("bp done after last xfer", 32'(done_cyc), 32'(last_xfer_cyc + 1));
    check("bp words left over", 32'(exp_data.size()), 32'd0);

    // Reset in cycle 4 of an 8-word burst, then a fresh burst.
    push_burst(8'h10, 9'd8, n);
    START = 1'b1; BASE_ADDR = 8'h10; LEN = 9'd8; OUT_READY = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge CLK);
      @(posedge CLK); #1;
      START = 1'b0;
      RST = (c + 1 == 4);
    end
    flush();
    for (int c = 5; c <= 9; c++) begin
      @(negedge CLK);
      check($sformatf("rst busy c%0d", c), 32'(BUSY), 32'd0);
      check($sformatf("rst done c%0d", c), 32'(DONE), 32'd0);
      check($sformatf("rst mem_en c%0d", c), 32'(MEM_EN), 32'd0);
      check($sformatf("rst valid c%0d", c), 32'(OUT_VALID), 32'd0);
      check($sformatf("rst out_data c%0d", c), 32'(OUT_DATA), 32'd0);
      @(posedge CLK); #1;
    end
    timed_burst(8'h20, 9'd2, 1'b0);

    // Random bursts with random memory contents and random backpressure.
    for (int b = 0; b < 40; b++) begin
      logic [7:0] base;
      logic [8:0] len;
      int r;
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      base = 8'($urandom);
      r = $urandom % 16;
      if (r < 2) len = 9'd0;
      else if (r == 2) len = 9'(257 + $urandom % 255);
      else len = 9'(1 + $urandom % 20);
      push_burst(base, len, n);
      START = 1'b1; BASE_ADDR = base; LEN = len; OUT_READY = ($urandom % 4) != 0;
      t0 = cyc;
      wait_done(8 * n + 40, 1'b1, done_cyc);
      if (done_cyc >= 0) begin
        if (n == 0) check($sformatf("rnd%0d empty done", b), 32'(done_cyc - t0), 32'd1);
        else check($sformatf("rnd%0d done after last xfer", b), 32'(done_cyc), 32'(last_xfer_cyc + 1));
        check($sformatf("rnd%0d words left", b), 32'(exp_data.size()), 32'd0);
        check($sformatf("rnd%0d reads left", b), 32'(exp_addr.size()), 32'd0);
      end
      START = 1'b0;
      @(negedge CLK);
      check($sformatf("rnd%0d done pulse ends", b), 32'(DONE), 32'd0);
      check($sformatf("rnd%0d idle busy", b), 32'(BUSY), 32'd0);
      @(posedge CLK); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
